// File: rtl/audio_playback_scheduler_if.sv
// Sample-memory read port shared by both playback channels.
// The master issues mem_rd/mem_addr; read data follows one cycle later.
interface audio_playback_scheduler_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) ();
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/audio_playback_scheduler.sv
// Two-channel sample player sharing one 1-cycle-latency memory port.
// A common prescaler sets the sample rate; each channel plays a region once or in a loop.
module audio_playback_scheduler #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int PRESCALE = 7000
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [1:0]           start,
    input  logic [1:0]           stop,
    input  logic [1:0]           loop,
    input  logic [ADDR_W-1:0]    base_l,
    input  logic [ADDR_W-1:0]    len_l,
    input  logic [ADDR_W-1:0]    base_r,
    input  logic [ADDR_W-1:0]    len_r,
    audio_playback_scheduler_if.master mem,
    output logic [DATA_W-1:0]    sample_l,
    output logic [DATA_W-1:0]    sample_r,
    output logic [1:0]           busy,
    output logic [1:0]           done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]     PRE_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] SILENCE  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_READ = 2'd1,
        F_CAP  = 2'd2
    } fstate_t;

    fstate_t fst_q, fst_d;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_s;

    logic [1:0] play_q, play_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] hold_q, hold_d;
    logic [1:0] done_q, done_d;
    logic [1:0] lp_q, lp_d;
    // Channel that wins the next contested arbitration (0 = left)
    logic       prio_q, prio_d;
    logic       ch_q, ch_d;
    logic       valid_q, valid_d;
    logic       rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [1:0][ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0][ADDR_W-1:0] rem_q, rem_d;
    logic [1:0][ADDR_W-1:0] base_q, base_d;
    logic [1:0][ADDR_W-1:0] len_q, len_d;
    logic [1:0][DATA_W-1:0] smp_q, smp_d;

    logic [1:0][ADDR_W-1:0] base_in_s;
    logic [1:0][ADDR_W-1:0] len_in_s;
    logic [1:0] start_ok_s;
    logic [1:0] kill_s;
    logic [1:0] eff_pend_s;
    logic       win_s;
    logic       ci_s;

    assign base_in_s = {base_r, base_l};
    assign len_in_s  = {len_r, len_l};

    // Free-running sample-rate prescaler
    always_comb begin
        tick_s = (pre_q == PRE_LAST);
        if (tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_ONE;
        end
    end

    // Per-channel start/stop qualification and effective pending requests
    always_comb begin
        start_ok_s = 2'b00;
        for (int c = 0; c < 2; c++) begin
            start_ok_s[c] = start[c] & ~stop[c] & (len_in_s[c] != '0);
        end
        // A start or stop cancels any request that has not yet reached the memory
        kill_s     = stop | start_ok_s;
        eff_pend_s = (pend_q | ({2{tick_s}} & play_q)) & ~kill_s;
    end

    // Fetch FSM, arbitration, capture and channel control next-state
    always_comb begin
        fst_d   = fst_q;
        prio_d  = prio_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        play_d  = play_q;
        hold_d  = hold_q;
        done_d  = 2'b00;
        pend_d  = eff_pend_s;
        lp_d    = lp_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        base_d  = base_q;
        len_d   = len_q;
        smp_d   = smp_q;
        win_s   = 1'b0;
        ci_s    = 1'b0;

        case (fst_q)
            F_IDLE: begin
                if (|eff_pend_s) begin
                    // Priority only rotates when both channels actually contend
                    if (&eff_pend_s) begin
                        win_s  = prio_q;
                        prio_d = ~prio_q;
                    end else begin
                        win_s  = eff_pend_s[1];
                    end
                    pend_d[win_s] = 1'b0;
                    rd_d          = 1'b1;
                    addr_d        = ptr_q[win_s];
                    ch_d          = win_s;
                    valid_d       = 1'b1;
                    fst_d         = F_READ;
                end else begin
                    fst_d = F_IDLE;
                end
            end
            F_READ: begin
                valid_d = valid_q & ~kill_s[ch_q];
                fst_d   = F_CAP;
            end
            F_CAP: begin
                valid_d = 1'b0;
                fst_d   = F_IDLE;
                if (valid_q && !kill_s[ch_q]) begin
                    smp_d[ch_q] = mem.mem_data;
                    ptr_d[ch_q] = ptr_q[ch_q] + A_ONE;
                    rem_d[ch_q] = rem_q[ch_q] - A_ONE;
                    if (rem_q[ch_q] == A_ONE) begin
                        if (lp_q[ch_q]) begin
                            ptr_d[ch_q] = base_q[ch_q];
                            rem_d[ch_q] = len_q[ch_q];
                        end else begin
                            play_d[ch_q] = 1'b0;
                            done_d[ch_q] = 1'b1;
                            hold_d[ch_q] = 1'b1;
                        end
                    end else begin
                        play_d[ch_q] = play_q[ch_q];
                    end
                end else begin
                    smp_d[ch_q] = smp_q[ch_q];
                end
            end
            default: begin
                fst_d   = F_IDLE;
                valid_d = 1'b0;
            end
        endcase

        for (int c = 0; c < 2; c++) begin
            ci_s = c[0];
            // A finished one-shot holds its last sample until the following tick
            if (tick_s && hold_q[ci_s]) begin
                smp_d[ci_s]  = SILENCE;
                hold_d[ci_s] = 1'b0;
            end else begin
                hold_d[ci_s] = hold_d[ci_s];
            end
            if (stop[ci_s]) begin
                play_d[ci_s] = 1'b0;
                hold_d[ci_s] = 1'b0;
                smp_d[ci_s]  = SILENCE;
            end else if (start_ok_s[ci_s]) begin
                play_d[ci_s] = 1'b1;
                hold_d[ci_s] = 1'b0;
                ptr_d[ci_s]  = base_in_s[ci_s];
                rem_d[ci_s]  = len_in_s[ci_s];
                base_d[ci_s] = base_in_s[ci_s];
                len_d[ci_s]  = len_in_s[ci_s];
                lp_d[ci_s]   = loop[ci_s];
            end else begin
                play_d[ci_s] = play_d[ci_s];
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            fst_q   <= F_IDLE;
            pre_q   <= '0;
            prio_q  <= 1'b0;
            ch_q    <= 1'b0;
            valid_q <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            play_q  <= 2'b00;
            pend_q  <= 2'b00;
            hold_q  <= 2'b00;
            done_q  <= 2'b00;
            lp_q    <= 2'b00;
            ptr_q   <= '0;
            rem_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            smp_q   <= {SILENCE, SILENCE};
        end else begin
            fst_q   <= fst_d;
            pre_q   <= pre_d;
            prio_q  <= prio_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            play_q  <= play_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            lp_q    <= lp_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            base_q  <= base_d;
            len_q   <= len_d;
            smp_q   <= smp_d;
        end
    end

    assign mem.mem_rd   = rd_q;
    assign mem.mem_addr = addr_q;
    assign sample_l     = smp_q[0];
    assign sample_r     = smp_q[1];
    assign busy         = play_q;
    assign done         = done_q;

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// Directed bench for audio_playback_scheduler: table-driven per-tick timing
// vectors plus hand-written sequences for stop, zero length and reset corners.
module tb_audio_playback_scheduler;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int PS = 16;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic [1:0]    start = 2'b00;
    logic [1:0]    stop = 2'b00;
    logic [1:0]    loop = 2'b00;
    logic [AW-1:0] base_l = '0, len_l = '0, base_r = '0, len_r = '0;
    logic [DW-1:0] sample_l, sample_r;
    logic [1:0]    busy, done;

    audio_playback_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    audio_playback_scheduler #(.ADDR_W(AW), .DATA_W(DW), .PRESCALE(PS)) u_dut (
        .clk      (clk),
        .Reset    (Reset),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .base_l   (base_l),
        .len_l    (len_l),
        .base_r   (base_r),
        .len_r    (len_r),
        .mem      (mem_if),
        .sample_l (sample_l),
        .sample_r (sample_r),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Memory model: each location holds its address low byte, 1-cycle latency
    always @(posedge clk) mem_if.mem_data <= mem_if.mem_addr[7:0];

    // Cycle index since reset; prescaler tick cycles are those with cyc % PS == PS-1
    int cyc = 0;
    always @(posedge clk) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          sc;
        int          tk;
        int          ofs;
        logic        rd;
        logic [11:0] addr;
        logic [7:0]  sl;
        logic [7:0]  sr;
        logic [1:0]  bsy;
        logic [1:0]  dn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int sc, input int tk, input int ofs, input logic rd,
                                input logic [11:0] addr, input logic [7:0] sl, input logic [7:0] sr,
                                input logic [1:0] bsy, input logic [1:0] dn);
        vec_t v;
        v.sc = sc; v.tk = tk; v.ofs = ofs; v.rd = rd; v.addr = addr;
        v.sl = sl; v.sr = sr; v.bsy = bsy; v.dn = dn;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int tgt);
        while (cyc < tgt) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1; start = 2'b00; stop = 2'b00; loop = 2'b00;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
    endtask

    // Pulse start for one cycle and return the first tick cycle after it
    task automatic start_cfg(input logic [1:0] st, input logic [1:0] lp,
                             input logic [11:0] bl, input logic [11:0] ll,
                             input logic [11:0] br, input logic [11:0] lr, output int t0);
        int cs;
        start = st; loop = lp; base_l = bl; len_l = ll; base_r = br; len_r = lr;
        cs = cyc;
        @(negedge clk);
        start = 2'b00;
        t0 = cs + 1;
        while ((t0 % PS) != PS - 1) t0++;
    endtask

    task automatic run_sc(input int sc);
        int t0;
        int tgt;
        do_reset();
        case (sc)
            0:       start_cfg(2'b01, 2'b00, 12'h010, 12'd4, 12'h000, 12'd0, t0);
            1:       start_cfg(2'b11, 2'b00, 12'h020, 12'd2, 12'h800, 12'd2, t0);
            2:       start_cfg(2'b10, 2'b10, 12'h000, 12'd0, 12'hFFE, 12'd4, t0);
            default: start_cfg(2'b00, 2'b00, 12'h000, 12'd0, 12'h000, 12'd0, t0);
        endcase
        foreach (vecs[i]) begin
            if (vecs[i].sc == sc) begin
                tgt = t0 + PS * vecs[i].tk + vecs[i].ofs;
                goto(tgt);
                chk($sformatf("sc%0d t%0d+%0d mem_rd", sc, vecs[i].tk, vecs[i].ofs), 32'(mem_if.mem_rd), 32'(vecs[i].rd));
                if (vecs[i].rd)
                    chk($sformatf("sc%0d t%0d+%0d mem_addr", sc, vecs[i].tk, vecs[i].ofs), 32'(mem_if.mem_addr), 32'(vecs[i].addr));
                chk($sformatf("sc%0d t%0d+%0d sample_l", sc, vecs[i].tk, vecs[i].ofs), 32'(sample_l), 32'(vecs[i].sl));
                chk($sformatf("sc%0d t%0d+%0d sample_r", sc, vecs[i].tk, vecs[i].ofs), 32'(sample_r), 32'(vecs[i].sr));
                chk($sformatf("sc%0d t%0d+%0d busy", sc, vecs[i].tk, vecs[i].ofs), 32'(busy), 32'(vecs[i].bsy));
                chk($sformatf("sc%0d t%0d+%0d done", sc, vecs[i].tk, vecs[i].ofs), 32'(done), 32'(vecs[i].dn));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        logic [7:0] sr_prev;
        logic [11:0] ra;

        // sc0: left one-shot, base 0x010, len 4
        add(0,0,0,1'b0,12'h000,8'h80,8'h80,2'b01,2'b00);
        add(0,0,1,1'b1,12'h010,8'h80,8'h80,2'b01,2'b00);
        add(0,0,2,1'b0,12'h000,8'h80,8'h80,2'b01,2'b00);
        add(0,0,3,1'b0,12'h000,8'h10,8'h80,2'b01,2'b00);
        add(0,1,1,1'b1,12'h011,8'h10,8'h80,2'b01,2'b00);
        add(0,1,3,1'b0,12'h000,8'h11,8'h80,2'b01,2'b00);
        add(0,2,1,1'b1,12'h012,8'h11,8'h80,2'b01,2'b00);
        add(0,2,3,1'b0,12'h000,8'h12,8'h80,2'b01,2'b00);
        add(0,3,1,1'b1,12'h013,8'h12,8'h80,2'b01,2'b00);
        add(0,3,2,1'b0,12'h000,8'h12,8'h80,2'b01,2'b00);
        add(0,3,3,1'b0,12'h000,8'h13,8'h80,2'b00,2'b01);
        add(0,3,4,1'b0,12'h000,8'h13,8'h80,2'b00,2'b00);
        add(0,4,0,1'b0,12'h000,8'h13,8'h80,2'b00,2'b00);
        add(0,4,1,1'b0,12'h000,8'h80,8'h80,2'b00,2'b00);
        // sc1: both one-shot, len 2; contested order alternates per tick
        add(1,0,0,1'b0,12'h000,8'h80,8'h80,2'b11,2'b00);
        add(1,0,1,1'b1,12'h020,8'h80,8'h80,2'b11,2'b00);
        add(1,0,3,1'b0,12'h000,8'h20,8'h80,2'b11,2'b00);
        add(1,0,4,1'b1,12'h800,8'h20,8'h80,2'b11,2'b00);
        add(1,0,6,1'b0,12'h000,8'h20,8'h00,2'b11,2'b00);
        add(1,1,1,1'b1,12'h801,8'h20,8'h00,2'b11,2'b00);
        add(1,1,3,1'b0,12'h000,8'h20,8'h01,2'b01,2'b10);
        add(1,1,4,1'b1,12'h021,8'h20,8'h01,2'b01,2'b00);
        add(1,1,6,1'b0,12'h000,8'h21,8'h01,2'b00,2'b01);
        add(1,1,7,1'b0,12'h000,8'h21,8'h01,2'b00,2'b00);
        add(1,2,0,1'b0,12'h000,8'h21,8'h01,2'b00,2'b00);
        add(1,2,1,1'b0,12'h000,8'h80,8'h80,2'b00,2'b00);
        // sc2: right looped region wrapping the top of memory
        sr_prev = 8'h80;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: ra = 12'hFFE;
                1: ra = 12'hFFF;
                2: ra = 12'h000;
                3: ra = 12'h001;
                default: ra = 12'hFFE;
            endcase
            add(2,k,1,1'b1,ra,8'h80,sr_prev,2'b10,2'b00);
            add(2,k,3,1'b0,12'h000,8'h80,ra[7:0],2'b10,2'b00);
            add(2,k,4,1'b0,12'h000,8'h80,ra[7:0],2'b10,2'b00);
            sr_prev = ra[7:0];
        end

        // Reset state and idle
        do_reset();
        for (int i = 0; i < 3 * PS; i++) begin
            @(negedge clk);
            chk("idle", 32'({mem_if.mem_rd, sample_l, sample_r, busy, done}),
                32'({1'b0, 8'h80, 8'h80, 2'b00, 2'b00}));
        end

        for (int s = 0; s < 3; s++) run_sc(s);

        // Stop left while its fetch is on the bus; right keeps playing
        do_reset();
        start_cfg(2'b11, 2'b00, 12'h010, 12'd4, 12'h800, 12'd4, t0);
        goto(t0 + PS + 3);
        chk("stop pre sample_l", 32'(sample_l), 32'h10);
        chk("stop pre sample_r", 32'(sample_r), 32'h01);
        goto(t0 + PS + 4);
        chk("stop left mem_rd", 32'(mem_if.mem_rd), 32'h1);
        chk("stop left mem_addr", 32'(mem_if.mem_addr), 32'h011);
        stop = 2'b01;
        @(negedge clk);
        stop = 2'b00;
        chk("stop sample_l", 32'(sample_l), 32'h80);
        chk("stop busy", 32'(busy), 32'h2);
        @(negedge clk);
        chk("stop discard sample_l", 32'(sample_l), 32'h80);
        goto(t0 + 2 * PS + 1);
        chk("stop right mem_rd", 32'(mem_if.mem_rd), 32'h1);
        chk("stop right mem_addr", 32'(mem_if.mem_addr), 32'h802);
        goto(t0 + 2 * PS + 3);
        chk("stop right sample_r", 32'(sample_r), 32'h02);
        chk("stop right sample_l", 32'(sample_l), 32'h80);

        // Zero-length start is ignored
        do_reset();
        start_cfg(2'b01, 2'b00, 12'h010, 12'd0, 12'h000, 12'd0, t0);
        chk("len0 busy", 32'(busy), 32'h0);
        goto(t0 + 1);
        chk("len0 mem_rd", 32'(mem_if.mem_rd), 32'h0);
        goto(t0 + 3);
        chk("len0 sample_l", 32'(sample_l), 32'h80);

        // Start and stop together while playing: stop wins
        do_reset();
        start_cfg(2'b01, 2'b00, 12'h010, 12'd4, 12'h000, 12'd0, t0);
        goto(t0 + 3);
        chk("ss pre sample_l", 32'(sample_l), 32'h10);
        start = 2'b01; stop = 2'b01;
        @(negedge clk);
        start = 2'b00; stop = 2'b00;
        chk("ss busy", 32'(busy), 32'h0);
        chk("ss sample_l", 32'(sample_l), 32'h80);
        goto(t0 + PS + 1);
        chk("ss next tick mem_rd", 32'(mem_if.mem_rd), 32'h0);

        // Reset in mid-fetch aborts the read
        do_reset();
        start_cfg(2'b01, 2'b00, 12'h010, 12'd4, 12'h000, 12'd0, t0);
        goto(t0 + PS + 1);
        chk("rst pre mem_rd", 32'(mem_if.mem_rd), 32'h1);
        chk("rst pre sample_l", 32'(sample_l), 32'h10);
        Reset = 1'b1;
        @(negedge clk);
        chk("rst mem_rd", 32'(mem_if.mem_rd), 32'h0);
        chk("rst sample_l", 32'(sample_l), 32'h80);
        chk("rst busy", 32'(busy), 32'h0);
        Reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
